sra_shift_sequencer: RTL
========================

# sra_shift_sequencer

Control sequencer for the signed arithmetic right-shift datapath. Accepts a start request with a shift amount, then issues one datapath load strobe followed by one shift strobe per cycle until the requested amount is consumed. It signals completion with a one-cycle done pulse and returns to idle. The block contains no data bits; the external shift register acts only on its strobes.

## Interface
- CNT_W, 3, width of shift-amount input and remaining-count register (max amount 2^CNT_W−1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Start  in  1  request; sampled only in IDLE
- Abort  in  1  cancel current operation; sampled in every state
- Amt  in  CNT_W  requested shift amount, captured on accepted Start
- Load  out  1  datapath: load operand this cycle
- Shift  out  1  datapath: arithmetic right shift by 1 this cycle
- Shift2  out  1  datapath: arithmetic right shift by 2 this cycle (0 unless SRA_DOUBLE_STEP_EN)
- Busy  out  1  high in any state except IDLE
- Done  out  1  one-cycle completion pulse
- Remain  out  CNT_W  remaining shift count register
- State  out  2  current state: IDLE=00, LOAD=01, SHIFT=10, DONE=11

## Operation
- Moore FSM, registered state. Load/Shift/Shift2/Done/Busy are decoded from state and Remain only.
- IDLE: on Start=1 with Abort=0, Remain <= Amt and go to LOAD. Otherwise stay.
- LOAD: Load=1. Next state is DONE if Remain==0, else SHIFT.
- SHIFT: Shift=1 and Remain <= Remain−1. Leave for DONE when Remain==1, i.e. after the last shift; otherwise stay.
- DONE: Done=1 for exactly one cycle, then IDLE. Remain holds 0.
- Abort=1 in LOAD/SHIFT/DONE: next state IDLE, Remain <= 0, no Done pulse. The strobe already asserted in the abort cycle still occurs.
- Abort=1 and Start=1 together in IDLE: Abort wins; stay IDLE.
- Start while Busy: ignored; not queued.
- Amt changes after acceptance: no effect.
- Strobes are mutually exclusive: at most one of Load, Shift, Shift2 and Done is high in any cycle.
- Remain never underflows: decrement occurs only when Remain≥1 (≥2 for Shift2).

## Timing
- Reset (async assert, sync-to-clk deassert by system): State=IDLE, Remain=0, Load=Shift=Shift2=Done=Busy=0.
- Reset asserted mid-operation: all outputs drop to reset values immediately. No Done.
- Start accepted at edge k: Load high in cycle k+1. Shift high in cycles k+2 … k+1+N. Done high in cycle k+2+N (N=Amt).
- N=0: Load in k+1, Done in k+2, no Shift.
- Busy rises in cycle k+1 and falls in the cycle after Done. A new Start is accepted at the first edge in IDLE, so back-to-back operations are separated by one IDLE cycle.
- Total occupancy: N+2 busy cycles (default mode).

## Configuration
- SRA_DOUBLE_STEP_EN defined: in SHIFT, when Remain≥2, Shift2=1, Shift=0 and Remain −= 2. When Remain==1, Shift=1. SHIFT exits to DONE when the step taken brings Remain to 0.
  - SHIFT cycles = ceil(N/2). Done at cycle k+2+ceil(N/2).
- SRA_DOUBLE_STEP_EN undefined: Shift2 tied to 0 and the single-step behaviour above applies. No other difference.

## Test plan
- Reset: rst_n=0 mid-SHIFT with Remain=5 → State=00, Remain=0, all strobes 0 within the same cycle. No Done after release.
- Amt=5, Start pulse at edge 0 → Load cycle 1, Shift cycles 2–6, Done cycle 7, Busy cycles 1–7. Remain sequence 5,5,4,3,2,1,0.
- Amt=0 → Load cycle 1, Done cycle 2, Shift never asserted.
- Amt=7, Start re-asserted every cycle while Busy, Abort asserted in SHIFT at Remain=4 → IDLE next cycle, Remain=0, no Done. A fresh Start is then accepted normally.
- Start=1 and Abort=1 in IDLE with Amt=3 → stays IDLE, Load never asserts. Start alone next cycle → Done 5 cycles after acceptance.
- SRA_DOUBLE_STEP_EN, Amt=5 → Load cycle 1, Shift2 cycles 2–3, Shift cycle 4, Done cycle 5. Amt=4 → Shift2 cycles 2–3, Done cycle 4, Shift never asserted.

Source files
------------

// File: rtl/sra_shift_sequencer.sv
// Strobe sequencer for the external signed arithmetic right-shift register.
// Define SRA_DOUBLE_STEP_EN to retire two shift positions per cycle when possible.
module sra_shift_sequencer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Abort,
    input  logic [CNT_W-1:0] Amt,
    output logic             Load,
    output logic             Shift,
    output logic             Shift2,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Remain,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] ZERO = '0;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);

    state_t st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= S_IDLE;
            Remain <= ZERO;
        end else if (Abort) begin
            // Abort wins everywhere; in IDLE this also blocks a same-cycle Start
            st     <= S_IDLE;
            Remain <= ZERO;
        end else begin
            unique case (st)
                S_IDLE: begin
                    if (Start) begin
                        Remain <= Amt;
                        st     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    st <= (Remain == ZERO) ? S_DONE : S_SHIFT;
                end
                S_SHIFT: begin
`ifdef SRA_DOUBLE_STEP_EN
                    if (Remain >= TWO) begin
                        Remain <= Remain - TWO;
                        if (Remain == TWO) st <= S_DONE;
                    end else if (Remain == ONE) begin
                        Remain <= ZERO;
                        st     <= S_DONE;
                    end else begin
                        st <= S_DONE;
                    end
`else
                    if (Remain >= ONE) begin
                        Remain <= Remain - ONE;
                        if (Remain == ONE) st <= S_DONE;
                    end else begin
                        st <= S_DONE;
                    end
`endif
                end
                S_DONE: begin
                    st     <= S_IDLE;
                    Remain <= ZERO;
                end
                default: begin
                    st     <= S_IDLE;
                    Remain <= ZERO;
                end
            endcase
        end
    end

    // Moore decode: strobes depend only on the registered state and count
    assign State = st;
    assign Busy  = (st != S_IDLE);
    assign Load  = (st == S_LOAD);
    assign Done  = (st == S_DONE);

`ifdef SRA_DOUBLE_STEP_EN
    assign Shift2 = (st == S_SHIFT) && (Remain >= TWO);
    assign Shift  = (st == S_SHIFT) && (Remain == ONE);
`else
    assign Shift2 = 1'b0;
    assign Shift  = (st == S_SHIFT) && (Remain >= ONE);
`endif

endmodule
